// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL startup/lock-loss supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int RELOCK_COUNT_W = 8;
  localparam int RETRY_W        = 4;

  // One spare bit above the largest terminal value keeps the compares unsigned-safe.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs; resets to zero.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL supervisor: sequences PLL reset, qualifies lock over a stable window,
// releases system reset, re-sequences on lock loss and latches a fault after repeated timeouts.
module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 1200,
  parameter int STABLE_CYCLES = 240,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                      REFERENCECLK,
  input  logic                      RESET,
  input  logic                      LOCK,
  output logic                      PLLRESET,
  output logic                      SYSRESET,
  output logic                      READY,
  output logic                      FAULT,
  output logic [RELOCK_COUNT_W-1:0] RELOCK_COUNT,
  output logic [2:0]                STATE
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_t                    r_state, w_next_state;
  logic [CNT_W-1:0]          r_cnt, w_next_cnt;
  logic [RETRY_W-1:0]        r_retries, w_next_retries;
  logic [RELOCK_COUNT_W-1:0] r_relock;
  logic                      w_relock_inc;
  logic                      w_lock_s;
  logic                      r_pllreset, r_sysreset, r_ready, r_fault;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .i_clk  (REFERENCECLK),
    .i_rst_n(RESET),
    .i_d    (LOCK),
    .o_q    (w_lock_s)
  );

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_next_retries = r_retries;
    w_relock_inc   = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_next_state = ST_WAIT_LOCK;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (w_lock_s) begin
          w_next_state = ST_STABLE;
          w_next_cnt   = '0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next_retries = r_retries + 1'b1;
          w_next_cnt     = '0;
          w_next_state   = (w_next_retries == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_next_state = ST_WAIT_LOCK;
          w_next_cnt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_next_state   = ST_RUN;
          w_next_cnt     = '0;
          w_next_retries = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_next_state = ST_HOLD;
          w_next_cnt   = '0;
          w_relock_inc = 1'b1;
        end
      end
      ST_FAULT: begin
        w_next_state = ST_FAULT;
      end
      default: begin
        w_next_state = ST_HOLD;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_HOLD;
      r_cnt      <= '0;
      r_retries  <= '0;
      r_relock   <= '0;
      r_pllreset <= 1'b0;
      r_sysreset <= 1'b0;
      r_ready    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_retries  <= w_next_retries;
      if (w_relock_inc && (r_relock != '1))
        r_relock <= r_relock + 1'b1;
      // Outputs decode the next state so they switch on the same edge as the state.
      r_pllreset <= (w_next_state != ST_HOLD) && (w_next_state != ST_FAULT);
      r_sysreset <= (w_next_state == ST_RUN);
      r_ready    <= (w_next_state == ST_RUN);
      r_fault    <= (w_next_state == ST_FAULT);
    end
  end

  assign PLLRESET     = r_pllreset;
  assign SYSRESET     = r_sysreset;
  assign READY        = r_ready;
  assign FAULT        = r_fault;
  assign RELOCK_COUNT = r_relock;
  assign STATE        = r_state;

endmodule

// File: tb/tb_pll_supervisor.sv
// Self-checking bench for pll_supervisor: per-cycle behavioural model plus directed and random LOCK stimulus.
module tb_pll_supervisor;

  localparam int HOLD_C   = 4;
  localparam int TIMEOUT  = 20;
  localparam int STABLE_C = 8;
  localparam int MAXR     = 2;

  localparam logic [2:0] P_HOLD = 3'd0, P_WAIT = 3'd1, P_STABLE = 3'd2, P_RUN = 3'd3, P_FAULT = 3'd4;

  logic       clk, RESET, LOCK;
  logic       PLLRESET, SYSRESET, READY, FAULT;
  logic [7:0] RELOCK_COUNT;
  logic [2:0] STATE;

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt;
  bit chk_on = 0;

  pll_supervisor #(
    .HOLD_CYCLES  (HOLD_C),
    .LOCK_TIMEOUT (TIMEOUT),
    .STABLE_CYCLES(STABLE_C),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .REFERENCECLK(clk),
    .RESET       (RESET),
    .LOCK        (LOCK),
    .PLLRESET    (PLLRESET),
    .SYSRESET    (SYSRESET),
    .READY       (READY),
    .FAULT       (FAULT),
    .RELOCK_COUNT(RELOCK_COUNT),
    .STATE       (STATE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: phase, edges spent in the phase, failed attempts, relock events.
  typedef struct packed {
    logic [2:0]  ph;
    logic [15:0] age;
    logic [3:0]  retries;
    logic [7:0]  relock;
  } mdl_t;

  mdl_t m;
  logic lk_d1, lk_d2;

  function automatic mdl_t step(input mdl_t c, input logic ls);
    mdl_t n;
    n     = c;
    n.age = c.age + 16'd1;
    case (c.ph)
      P_HOLD:
        if (n.age == 16'(HOLD_C)) begin n.ph = P_WAIT; n.age = '0; end
      P_WAIT:
        if (ls) begin
          n.ph = P_STABLE; n.age = '0;
        end else if (n.age == 16'(TIMEOUT)) begin
          n.retries = c.retries + 4'd1;
          n.ph      = (n.retries == 4'(MAXR)) ? P_FAULT : P_HOLD;
          n.age     = '0;
        end
      P_STABLE:
        if (!ls) begin
          n.ph = P_WAIT; n.age = '0;
        end else if (n.age == 16'(STABLE_C)) begin
          n.ph = P_RUN; n.age = '0; n.retries = '0;
        end
      P_RUN:
        if (!ls) begin
          n.ph  = P_HOLD; n.age = '0;
          n.relock = (c.relock == 8'd255) ? 8'd255 : c.relock + 8'd1;
        end
      default: n.age = c.age;
    endcase
    return n;
  endfunction

  // The FSM at edge n acts on LOCK as sampled at edge n-2.
  always @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      m     <= '0;
      lk_d1 <= 1'b0;
      lk_d2 <= 1'b0;
    end else begin
      lk_d1 <= LOCK;
      lk_d2 <= lk_d1;
      m     <= step(m, lk_d2);
    end
  end

  always @(posedge clk or negedge RESET) begin
    if (!RESET) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, ecnt, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("state",    32'(STATE),        32'(m.ph));
      check("pllreset", 32'(PLLRESET),     32'(m.ph == P_WAIT || m.ph == P_STABLE || m.ph == P_RUN));
      check("sysreset", 32'(SYSRESET),     32'(m.ph == P_RUN));
      check("ready",    32'(READY),        32'(m.ph == P_RUN));
      check("fault",    32'(FAULT),        32'(m.ph == P_FAULT));
      check("relock",   32'(RELOCK_COUNT), 32'(m.relock));
    end
  end

  task automatic do_reset();
    RESET = 1'b0;
    LOCK  = 1'b0;
    repeat (2) @(negedge clk);
    RESET = 1'b1;
  endtask

  task automatic at_edge(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  task automatic wait_ready(input string name, input int budget);
    int k;
    k = 0;
    while (!READY && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(READY), 32'(1));
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int budget);
    int k;
    k = 0;
    while (STATE != st && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(STATE), 32'(st));
  endtask

  task automatic lock_blip();
    LOCK = 1'b0;
    @(negedge clk);
    LOCK = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int j;
    RESET = 1'b1;
    LOCK  = 1'b0;
    #3;
    do_reset();
    chk_on = 1;

    // Clean start
    at_edge(3);  check("clean_pllrst_e3", 32'(PLLRESET), 32'(0));
    at_edge(4);  check("clean_pllrst_e4", 32'(PLLRESET), 32'(1));
    at_edge(9);  LOCK = 1'b1;
    at_edge(19); check("clean_ready_e19", 32'(READY), 32'(0));
    at_edge(20); check("clean_ready_e20", 32'(READY), 32'(1));
    check("clean_sysrst_e20", 32'(SYSRESET), 32'(1));
    check("clean_relock", 32'(RELOCK_COUNT), 32'(0));

    // Relock: LOCK low for three samples
    j = ecnt;
    LOCK = 1'b0;
    at_edge(j + 2); check("relock_sys_hold", 32'(SYSRESET), 32'(1));
    at_edge(j + 3); check("relock_sys_fall", 32'(SYSRESET), 32'(0));
    check("relock_pll_fall", 32'(PLLRESET), 32'(0));
    LOCK = 1'b1;
    wait_ready("relock_ready", 60);
    check("relock_count1", 32'(RELOCK_COUNT), 32'(1));

    // Saturation: 260 further lock losses
    for (int i = 0; i < 260; i++) begin
      lock_blip();
      wait_ready("sat_ready", 60);
    end
    check("sat_count", 32'(RELOCK_COUNT), 32'(255));

    // Async reset mid-STABLE
    lock_blip();
    wait_state("reach_stable", P_STABLE, 60);
    #1 RESET = 1'b0;
    #1;
    check("arst_state",  32'(STATE),        32'(P_HOLD));
    check("arst_pll",    32'(PLLRESET),     32'(0));
    check("arst_sys",    32'(SYSRESET),     32'(0));
    check("arst_ready",  32'(READY),        32'(0));
    check("arst_fault",  32'(FAULT),        32'(0));
    check("arst_relock", 32'(RELOCK_COUNT), 32'(0));
    do_reset();

    // Unstable lock: high 5 samples, low 1, then high
    at_edge(9);  LOCK = 1'b1;
    at_edge(14); LOCK = 1'b0;
    at_edge(15); LOCK = 1'b1;
    at_edge(16); check("unst_stable", 32'(STATE), 32'(P_STABLE));
    at_edge(17); check("unst_back_wait", 32'(STATE), 32'(P_WAIT));
    at_edge(25); check("unst_sys_e25", 32'(SYSRESET), 32'(0));
    at_edge(26); check("unst_sys_e26", 32'(SYSRESET), 32'(1));
    do_reset();

    // Fault: LOCK never rises
    at_edge(47);  check("fault_e47", 32'(FAULT), 32'(0));
    at_edge(48);  check("fault_e48", 32'(FAULT), 32'(1));
    check("fault_pll_e48", 32'(PLLRESET), 32'(0));
    at_edge(148); check("fault_e148", 32'(FAULT), 32'(1));
    check("fault_pll_e148", 32'(PLLRESET), 32'(0));
    do_reset();

    // Timeout/lock tie: lock_s first high on the last timeout cycle
    at_edge(21); LOCK = 1'b1;
    at_edge(23); check("tie_wait", 32'(STATE), 32'(P_WAIT));
    at_edge(24); check("tie_stable", 32'(STATE), 32'(P_STABLE));
    at_edge(31); check("tie_ready_e31", 32'(READY), 32'(0));
    at_edge(32); check("tie_ready_e32", 32'(READY), 32'(1));

    // Random LOCK segments with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if (FAULT) do_reset();
      LOCK = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 30)) @(negedge clk);
      if ($urandom_range(0, 24) == 0) begin
        #($urandom_range(1, 4));
        RESET = 1'b0;
        @(negedge clk);
        RESET = 1'b1;
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Startup and lock-loss supervisor for the iCE40 PLL, running on the 12 MHz reference clock. It drives the PLL's active-low reset, watches the PLL lock output, and releases an active-low system reset only after lock has been stable for a programmable time. On lock loss it re-sequences the PLL. After repeated lock timeouts it latches a fault. It sits between the board reset pin and the PLL instance; its system-reset output feeds the per-domain reset synchronizers of the pulse-generation logic.

## Interface
Parameters:
- HOLD_CYCLES, 16: cycles PLLRESET is held low per attempt (≥1).
- LOCK_TIMEOUT, 1200: cycles allowed in WAIT_LOCK before an attempt fails (100 µs at 12 MHz, ≥2).
- STABLE_CYCLES, 240: consecutive synchronized-lock cycles required before release (≥1).
- MAX_RETRIES, 3: failed attempts before FAULT (1..15).

Ports:
- REFERENCECLK  in  1  12 MHz clock; the only clock.
- RESET  in  1  asynchronous, active-low reset.
- LOCK  in  1  PLL lock, asynchronous to REFERENCECLK.
- PLLRESET  out  1  active-low; connects to PLL RESETB.
- SYSRESET  out  1  active-low system reset.
- READY  out  1  high in RUN.
- FAULT  out  1  high in FAULT.
- RELOCK_COUNT  out  8  saturating count of RUN→HOLD lock-loss events.
- STATE  out  3  current state encoding, for debug.

## Operation
- LOCK passes through a 2-flop synchronizer to give lock_s. No other logic reads LOCK directly.
- States, with encodings in the package: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- **HOLD**
  - PLLRESET=0, SYSRESET=0.
  - Stays exactly HOLD_CYCLES cycles, then goes to WAIT_LOCK with cnt cleared.
- **WAIT_LOCK**
  - PLLRESET=1, SYSRESET=0, cnt increments.
  - lock_s=1 → STABLE, cnt cleared.
  - Otherwise, when cnt=LOCK_TIMEOUT-1, retries increments. If the new value equals MAX_RETRIES → FAULT; else → HOLD.
  - If lock_s=1 and the timeout fall on the same cycle, lock wins and the state goes to STABLE.
- **STABLE**
  - PLLRESET=1, SYSRESET=0.
  - lock_s=0 → WAIT_LOCK with cnt cleared. The timeout window restarts; retries is unchanged.
  - After STABLE_CYCLES consecutive cycles with lock_s=1 → RUN, and retries clears.
- **RUN**
  - PLLRESET=1, SYSRESET=1, READY=1.
  - lock_s=0 → HOLD, and RELOCK_COUNT increments, saturating at 255.
- **FAULT**
  - Terminal until RESET asserts.
  - PLLRESET=0, SYSRESET=0, FAULT=1.
- cnt width is $clog2 of the largest of HOLD_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, plus 1. retries is 4 bits.
- RELOCK_COUNT clears only on RESET, not on FAULT.

## Timing
- All outputs are registered and decoded from the next state, so an output changes on the same edge as its state change.
- Reset values while RESET=0: state=HOLD, PLLRESET=0, SYSRESET=0, READY=0, FAULT=0, RELOCK_COUNT=0, cnt=0, retries=0, synchronizer flops=0.
- Startup: after RESET deasserts, PLLRESET stays 0 for HOLD_CYCLES rising edges, then goes to 1.
- Lock release latency:
  - LOCK sampled high at edge k → lock_s=1 after edge k+1 → STABLE entered at edge k+2.
  - SYSRESET rises at edge k+2+STABLE_CYCLES.
- Lock loss: LOCK sampled low at edge k in RUN → SYSRESET and PLLRESET fall at edge k+2.
- A LOCK glitch shorter than one cycle may be missed. No filtering is required beyond the STABLE window.
- RESET asserted mid-operation forces all reset values immediately (asynchronous), including dropping SYSRESET.

## Structure
- Package pll_sup_pkg holds:
  - the state typedef and encodings;
  - the counter-width function;
  - RELOCK_COUNT_W=8.
- Sub-module sync2: a generic 2-flop synchronizer with parameter width and reset value 0. It is reused elsewhere for other asynchronous inputs.
- The supervisor itself is one FSM plus two counters.

## Test plan
Bench parameters: HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- **Clean start:** release RESET; raise LOCK at edge 10 → PLLRESET=0 for edges 1–4. READY and SYSRESET rise at edge 10+2+8=20. RELOCK_COUNT=0.
- **Unstable lock:** LOCK high for 5 cycles, low for 1, then high → state returns to WAIT_LOCK. SYSRESET rises 10 cycles after the final LOCK rise. retries=0.
- **Fault:** LOCK held low → two 20-cycle timeouts, each followed by a 4-cycle HOLD. FAULT=1 and PLLRESET=0 after the second timeout, and they persist for 100 further cycles.
- **Relock:** in RUN, drop LOCK for 3 cycles, then restore → SYSRESET falls 2 cycles after the drop. The HOLD/WAIT/STABLE sequence repeats. RELOCK_COUNT=1; READY returns.
- **Saturation and async reset:** force 260 lock losses → RELOCK_COUNT=255. Then assert RESET mid-STABLE → all outputs take reset values before the next clock edge.
- **Timeout/lock tie:** LOCK rises such that lock_s=1 on the cycle cnt=19 → state goes to STABLE, not HOLD. retries is unchanged.
